// File: rtl/simon96_96_core.sv
// Iterative SIMON 96/96 core: internal key expansion into a round-key store, one round per clock.
// Optional macro SIMON9696_MODE_EN exports both FSM states on mode; otherwise mode is tied to zero.
module simon96_96_core #(
  parameter int N  = 48,
  parameter int M  = 2,
  parameter int T  = 52,
  parameter int Co = 6
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  newKey,
  input  logic [M-1:0][N-1:0]   KEY,
  output logic                  loadKey,
  output logic                  doneKey,
  input  logic                  newData,
  input  logic                  enc_dec,
  input  logic [1:0][N-1:0]     blockIN,
  output logic                  loadData,
  output logic                  doneData,
  input  logic                  readData,
  output logic [1:0][N-1:0]     outData,
  output logic [3:0]            mode
);

  typedef enum logic [1:0] {KIDLE = 2'd0, KEXP = 2'd1, KRDY = 2'd2} key_state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} data_state_t;

  localparam logic [61:0]   Z2     = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [Co-1:0] LAST   = Co'(T - 1);
  localparam logic [Co-1:0] FINAL  = Co'(T);
  localparam logic [N-1:0]  CONST3 = N'(3);

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] fr(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  key_state_t      r_kst;
  data_state_t     r_dst;
  logic [N-1:0]    r_rk [T];
  logic [N-1:0]    r_kp1;
  logic [N-1:0]    r_kp2;
  logic [Co-1:0]   r_kidx;
  logic [5:0]      r_zidx;
  logic            r_key_armed;
  logic            r_load_key;
  logic            r_done_key;

  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic            r_enc;
  logic [Co-1:0]   r_rnd;
  logic            r_load_data;
  logic            r_done_data;
  logic [N-1:0]    r_out_x;
  logic [N-1:0]    r_out_y;

  logic            w_key_start;
  logic            w_data_start;
  logic [N-1:0]    w_tmp;
  logic [N-1:0]    w_tmp2;
  logic            w_zbit;
  logic [N-1:0]    w_newk;
  logic [Co-1:0]   w_ridx;
  logic [N-1:0]    w_rk;

  // A pending key load wins over a pending block so the schedule is never swapped under a run.
  assign w_key_start  = ((r_kst == KIDLE) || (r_kst == KRDY)) && newKey && r_key_armed
                        && (r_dst != RUN);
  assign w_data_start = (r_dst == IDLE) && newData && r_done_key && !w_key_start;

  assign w_tmp  = ror(r_kp1, 3);
  assign w_tmp2 = w_tmp ^ ror(w_tmp, 1);
  assign w_zbit = Z2[6'd61 - r_zidx];
  assign w_newk = ~r_kp2 ^ w_tmp2 ^ {{(N-1){1'b0}}, w_zbit} ^ CONST3;

  assign w_ridx = (r_rnd < FINAL) ? (r_enc ? r_rnd : (LAST - r_rnd)) : '0;
  assign w_rk   = r_rk[w_ridx];

  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      r_kst       <= KIDLE;
      for (int i = 0; i < T; i++) r_rk[i] <= '0;
      r_kp1       <= '0;
      r_kp2       <= '0;
      r_kidx      <= '0;
      r_zidx      <= '0;
      r_key_armed <= 1'b1;
      r_load_key  <= 1'b0;
      r_done_key  <= 1'b0;
    end else begin
      r_load_key <= 1'b0;
      if (!newKey) r_key_armed <= 1'b1;
      case (r_kst)
        KIDLE, KRDY: begin
          if (w_key_start) begin
            r_rk[0]     <= KEY[0];
            r_rk[1]     <= KEY[1];
            r_kp2       <= KEY[0];
            r_kp1       <= KEY[1];
            r_kidx      <= Co'(2);
            r_zidx      <= '0;
            r_key_armed <= 1'b0;
            r_load_key  <= 1'b1;
            r_done_key  <= 1'b0;
            r_kst       <= KEXP;
          end
        end
        KEXP: begin
          r_rk[r_kidx] <= w_newk;
          r_kp2        <= r_kp1;
          r_kp1        <= w_newk;
          r_zidx       <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
          if (r_kidx == LAST) begin
            r_done_key <= 1'b1;
            r_kst      <= KRDY;
          end else begin
            r_kidx <= r_kidx + Co'(1);
          end
        end
        default: r_kst <= KIDLE;
      endcase
    end
  end

  // RUN spends T cycles on rounds and one more cycle presenting the result.
  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      r_dst       <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_enc       <= 1'b0;
      r_rnd       <= '0;
      r_load_data <= 1'b0;
      r_done_data <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_load_data <= 1'b0;
      case (r_dst)
        IDLE: begin
          if (w_data_start) begin
            r_x         <= blockIN[1];
            r_y         <= blockIN[0];
            r_enc       <= enc_dec;
            r_rnd       <= '0;
            r_load_data <= 1'b1;
            r_dst       <= RUN;
          end
        end
        RUN: begin
          if (r_rnd == FINAL) begin
            r_out_x     <= r_x;
            r_out_y     <= r_y;
            r_done_data <= 1'b1;
            r_dst       <= DONE;
          end else begin
            if (r_enc) begin
              r_x <= r_y ^ fr(r_x) ^ w_rk;
              r_y <= r_x;
            end else begin
              r_x <= r_y;
              r_y <= r_x ^ fr(r_y) ^ w_rk;
            end
            r_rnd <= r_rnd + Co'(1);
          end
        end
        DONE: begin
          if (readData) begin
            r_done_data <= 1'b0;
            r_dst       <= IDLE;
          end
        end
        default: r_dst <= IDLE;
      endcase
    end
  end

  assign loadKey  = r_load_key;
  assign doneKey  = r_done_key;
  assign loadData = r_load_data;
  assign doneData = r_done_data;
  assign outData  = {r_out_x, r_out_y};

`ifdef SIMON9696_MODE_EN
  assign mode = {r_kst, r_dst};
`else
  assign mode = 4'b0000;
`endif

endmodule

// File: tb/tb_simon96_96_core.sv
// Directed bench for simon96_96_core: known-answer encrypt/decrypt, streaming handshake,
// latency, key-load pulse behaviour and mid-run reset.
module tb_simon96_96_core;
  localparam int N = 48;

  logic                clk = 1'b0;
  logic                nR;
  logic                newKey;
  logic [1:0][N-1:0]   KEY;
  logic                loadKey;
  logic                doneKey;
  logic                newData;
  logic                enc_dec;
  logic [1:0][N-1:0]   blockIN;
  logic                loadData;
  logic                doneData;
  logic                readData;
  logic [1:0][N-1:0]   outData;
  logic [3:0]          mode;

  int errors = 0;
  int checks = 0;
  int n_lk = 0;
  int n_ld = 0;
  bit lk_multi = 0, ld_multi = 0, prev_lk = 0, prev_ld = 0, mode_nz = 0;

  logic [95:0] pt [5];
  logic [95:0] ct [5];
  logic [95:0] res;

  always #5 clk = ~clk;

  simon96_96_core dut (
    .clk(clk), .nR(nR), .newKey(newKey), .KEY(KEY), .loadKey(loadKey), .doneKey(doneKey),
    .newData(newData), .enc_dec(enc_dec), .blockIN(blockIN), .loadData(loadData),
    .doneData(doneData), .readData(readData), .outData(outData), .mode(mode)
  );

  always @(negedge clk) begin
    if (loadKey) n_lk++;
    if (loadKey && prev_lk) lk_multi = 1;
    prev_lk = loadKey;
    if (loadData) n_ld++;
    if (loadData && prev_ld) ld_multi = 1;
    prev_ld = loadData;
    if (mode != 4'd0) mode_nz = 1;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input logic [95:0] blk, input bit enc, input string tag,
                           output logic [95:0] r);
    bit got;
    int lat;
    blockIN = blk;
    enc_dec = enc;
    newData = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (loadData) got = 1;
    end
    check($sformatf("%s loadData", tag), 96'(got), 96'd1);
    newData = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check($sformatf("%s loadData pulse", tag), 96'(loadData), 96'd0);
      if (doneData) got = 1;
    end
    check($sformatf("%s latency", tag), 96'(lat), 96'd53);
    r = outData;
  endtask

  task automatic hold_and_read(input logic [95:0] held, input logic [95:0] nxt,
                               input bit nxt_enc, input bit renew, input string tag);
    bit stable;
    bit early;
    blockIN = nxt;
    enc_dec = nxt_enc;
    newData = renew;
    stable = 1;
    early = 0;
    repeat (4) begin
      @(negedge clk);
      if (!doneData || (outData !== held)) stable = 0;
      if (loadData) early = 1;
    end
    check($sformatf("%s held", tag), 96'(stable), 96'd1);
    check($sformatf("%s no load before read", tag), 96'(early), 96'd0);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    check($sformatf("%s doneData cleared", tag), 96'(doneData), 96'd0);
  endtask

  initial begin
    bit got;
    bit early;
    int ld_before;
    pt[0] = 96'h2072616C6C69702065687420;
    pt[1] = 96'hA8D5F7DE0123FEDC01234567;
    pt[2] = 96'h5BC92D014567BA9889ABCDEF;
    pt[3] = 96'hF2B48D4589AB765401234567;
    pt[4] = 96'h567F11DECDEF321089ABCDEF;

    nR = 1'b1; newKey = 1'b0; KEY = '0; newData = 1'b0; enc_dec = 1'b0;
    blockIN = '0; readData = 1'b0;
    repeat (3) @(negedge clk);
    check("reset loadKey", 96'(loadKey), 96'd0);
    check("reset doneKey", 96'(doneKey), 96'd0);
    check("reset loadData", 96'(loadData), 96'd0);
    check("reset doneData", 96'(doneData), 96'd0);
    check("reset outData", outData, 96'd0);
    check("reset mode", 96'(mode), 96'd0);
    nR = 1'b0;

    @(negedge clk);
    KEY[1] = 48'h0D0C0B0A0908;
    KEY[0] = 48'h050403020100;
    blockIN = pt[0];
    enc_dec = 1'b1;
    newKey = 1'b1;
    newData = 1'b1;
    got = 0;
    early = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (loadKey) got = 1;
      if (loadData) early = 1;
    end
    check("loadKey seen", 96'(got), 96'd1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (doneKey) got = 1;
      if (loadData) early = 1;
    end
    check("doneKey seen", 96'(got), 96'd1);
    check("data waits for key", 96'(early), 96'd0);

    run_block(pt[0], 1'b1, "kat enc", res);
    check("kat ciphertext", res, 96'h602807A462B469063D8FF082);
`ifdef SIMON9696_MODE_EN
    check("mode in DONE", 96'(mode), 96'hA);
`endif
    hold_and_read(96'h602807A462B469063D8FF082, 96'h602807A462B469063D8FF082, 1'b0, 1'b1, "kat enc");
    run_block(96'h602807A462B469063D8FF082, 1'b0, "kat dec", res);
    check("kat plaintext", res, pt[0]);
    check("single key load with newKey held", 96'(n_lk), 96'd1);
    check("loadKey single pulse", 96'(lk_multi), 96'd0);
    check("doneKey kept", 96'(doneKey), 96'd1);
    newKey = 1'b0;
    hold_and_read(pt[0], pt[0], 1'b1, 1'b1, "kat dec");

    for (int k = 0; k < 5; k++) begin
      run_block(pt[k], 1'b1, $sformatf("stream enc %0d", k), res);
      ct[k] = res;
      if (k == 0) check("stream ct0", res, 96'h602807A462B469063D8FF082);
      if (k < 4) hold_and_read(res, pt[k+1], 1'b1, 1'b1, $sformatf("stream enc %0d", k));
      else       hold_and_read(res, ct[0], 1'b0, 1'b1, $sformatf("stream enc %0d", k));
    end
    for (int k = 0; k < 5; k++) begin
      run_block(ct[k], 1'b0, $sformatf("stream dec %0d", k), res);
      check($sformatf("stream roundtrip %0d", k), res, pt[k]);
      if (k < 4) hold_and_read(res, ct[k+1], 1'b0, 1'b1, $sformatf("stream dec %0d", k));
      else       hold_and_read(res, pt[0], 1'b1, 1'b0, $sformatf("stream dec %0d", k));
    end
    check("loadData single pulse", 96'(ld_multi), 96'd0);

    blockIN = pt[1];
    enc_dec = 1'b1;
    newData = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (loadData) got = 1;
    end
    check("abort run loadData", 96'(got), 96'd1);
    newData = 1'b0;
    repeat (20) @(negedge clk);
    nR = 1'b1;
    #1;
    check("abort loadKey", 96'(loadKey), 96'd0);
    check("abort doneKey", 96'(doneKey), 96'd0);
    check("abort loadData", 96'(loadData), 96'd0);
    check("abort doneData", 96'(doneData), 96'd0);
    check("abort outData", outData, 96'd0);
    check("abort mode", 96'(mode), 96'd0);
    @(negedge clk);
    nR = 1'b0;
    ld_before = n_ld;
    newData = 1'b1;
    got = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (loadData || doneData) got = 1;
    end
    newData = 1'b0;
    check("no load without key", 96'(got), 96'd0);
    check("no load count", 96'(n_ld - ld_before), 96'd0);
    check("doneKey after reset", 96'(doneKey), 96'd0);
`ifdef SIMON9696_MODE_EN
    check("mode exported", 96'(mode_nz), 96'd1);
`else
    check("mode tied low", 96'(mode_nz), 96'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
